// File: rtl/led_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_pattern_gen                                               |
// | Brief    : LED bank driver with off/blink/marquee/breathe modes and a     |
// |            step strobe. Define LED_ACTIVE_LOW_EN for active-low boards.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module led_pattern_gen #(
  parameter int LED_NUM     = 8,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int PWM_BITS    = 8,
  parameter int BREATH_DIV  = 256
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step_tick
);

  localparam int c_step_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int c_div_w  = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;

  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_CYCLES - 1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(BREATH_DIV - 1);
  localparam logic [PWM_BITS-1:0] c_duty_max  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] c_duty_min  = '0;
  localparam logic [LED_NUM-1:0]  c_led_one   = LED_NUM'(1);

  localparam logic [1:0] c_mode_off     = 2'b00;
  localparam logic [1:0] c_mode_blink   = 2'b01;
  localparam logic [1:0] c_mode_marquee = 2'b10;
  localparam logic [1:0] c_mode_breathe = 2'b11;

  logic [1:0]          r_mode_q,   w_mode_nxt;
  logic [c_step_w-1:0] r_step_cnt, w_step_nxt;
  logic [c_div_w-1:0]  r_div_cnt,  w_div_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt,  w_pwm_nxt;
  logic [PWM_BITS-1:0] r_duty,     w_duty_nxt;
  logic                r_dir_up,   w_dir_up_nxt;
  logic [LED_NUM-1:0]  r_pattern,  w_pattern_nxt;
  logic                r_step_tick, w_step_tick_nxt;

  logic [LED_NUM-1:0]  w_rot;
  logic [PWM_BITS-1:0] w_duty_inc;
  logic [PWM_BITS-1:0] w_duty_dec;
  logic                w_pwm_on;
  logic                w_pwm_wrap;

  assign w_duty_inc = r_duty + 1'b1;
  assign w_duty_dec = r_duty - 1'b1;
  assign w_pwm_on   = (r_pwm_cnt < r_duty);
  assign w_pwm_wrap = &r_pwm_cnt;

  // A single LED has nothing to rotate into, so it simply stays lit.
  generate
    if (LED_NUM == 1) begin : g_rot_single
      assign w_rot = r_pattern;
    end else begin : g_rot_multi
      assign w_rot = {r_pattern[LED_NUM-2:0], r_pattern[LED_NUM-1]};
    end
  endgenerate

  always_comb begin
    w_mode_nxt      = r_mode_q;
    w_step_nxt      = r_step_cnt;
    w_div_nxt       = r_div_cnt;
    w_pwm_nxt       = r_pwm_cnt + 1'b1;
    w_duty_nxt      = r_duty;
    w_dir_up_nxt    = r_dir_up;
    w_pattern_nxt   = r_pattern;
    w_step_tick_nxt = 1'b0;

    if (mode != r_mode_q) begin
      w_mode_nxt    = mode;
      w_step_nxt    = '0;
      w_div_nxt     = '0;
      w_pattern_nxt = '0;
      if (mode == c_mode_marquee) begin
        w_pattern_nxt = c_led_one;
      end
      if (mode == c_mode_breathe) begin
        w_duty_nxt   = c_duty_min;
        w_dir_up_nxt = 1'b1;
      end
    end else begin
      case (r_mode_q)
        c_mode_blink, c_mode_marquee: begin
          if (!pause) begin
            if (r_step_cnt == c_step_last) begin
              w_step_nxt      = '0;
              w_step_tick_nxt = 1'b1;
              w_pattern_nxt   = (r_mode_q == c_mode_blink) ? ~r_pattern : w_rot;
            end else begin
              w_step_nxt = r_step_cnt + 1'b1;
            end
          end
        end
        c_mode_breathe: begin
          w_step_nxt    = '0;
          w_pattern_nxt = {LED_NUM{w_pwm_on}};
          // Direction flips on reaching an end, so duty never wraps.
          if (!pause && w_pwm_wrap) begin
            if (r_div_cnt == c_div_last) begin
              w_div_nxt       = '0;
              w_step_tick_nxt = 1'b1;
              if (r_dir_up) begin
                w_duty_nxt = w_duty_inc;
                if (w_duty_inc == c_duty_max) begin
                  w_dir_up_nxt = 1'b0;
                end
              end else begin
                w_duty_nxt = w_duty_dec;
                if (w_duty_dec == c_duty_min) begin
                  w_dir_up_nxt = 1'b1;
                end
              end
            end else begin
              w_div_nxt = r_div_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_step_nxt    = '0;
          w_pattern_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mode_q    <= c_mode_off;
      r_step_cnt  <= '0;
      r_div_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_duty      <= '0;
      r_dir_up    <= 1'b1;
      r_pattern   <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_mode_q    <= w_mode_nxt;
      r_step_cnt  <= w_step_nxt;
      r_div_cnt   <= w_div_nxt;
      r_pwm_cnt   <= w_pwm_nxt;
      r_duty      <= w_duty_nxt;
      r_dir_up    <= w_dir_up_nxt;
      r_pattern   <= w_pattern_nxt;
      r_step_tick <= w_step_tick_nxt;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~r_pattern;
`else
  assign led = r_pattern;
`endif

  assign step_tick = r_step_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_pattern_gen                                            |
// | Brief    : Self-checking bench for led_pattern_gen against a step-count   |
// |            reference model.                                              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int PB = 3;
  localparam int BD = 2;
  localparam int PWM_PERIOD = 1 << PB;
  localparam int FADE = 2 * (PWM_PERIOD - 1);
  localparam logic [N-1:0] ALL_ON = '1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         pause = 1'b0;
  logic [N-1:0] led;
  logic         step_tick;

  int total = 0;
  int bad   = 0;

  // Reference model: everything is derived from counts of elapsed events.
  int           m_mode  = 0;
  int           m_time  = 0;
  int           m_cnt   = 0;
  int           m_wraps = 0;
  logic [N-1:0] exp_led = '0;
  logic         exp_tick = 1'b0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .LED_NUM    (N),
    .STEP_CYCLES(SC),
    .PWM_BITS   (PB),
    .BREATH_DIV (BD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .pause    (pause),
    .led      (led),
    .step_tick(step_tick)
  );

  function automatic int tri_duty(input int k);
    int p;
    p = k % FADE;
    return (p <= PWM_PERIOD - 1) ? p : FADE - p;
  endfunction

  function automatic int model_duty();
    return tri_duty(m_wraps / BD);
  endfunction

  task automatic cycle(input logic r, input logic [1:0] md, input logic p);
    int pwm_before;
    int duty_before;
    rstn  = r;
    mode  = md;
    pause = p;
    @(posedge clk);
    #1;
    if (!r) begin
      m_mode = 0; m_time = 0; m_cnt = 0; m_wraps = 0;
      exp_led = '0; exp_tick = 1'b0;
    end else begin
      pwm_before  = m_time % PWM_PERIOD;
      duty_before = model_duty();
      m_time++;
      exp_tick = 1'b0;
      if (int'(md) != m_mode) begin
        m_mode = int'(md); m_cnt = 0; m_wraps = 0;
        exp_led = (md == 2'b10) ? N'(1) : '0;
      end else begin
        case (m_mode)
          1: begin
            if (!p) begin
              m_cnt++;
              if (m_cnt % SC == 0) exp_tick = 1'b1;
            end
            exp_led = (((m_cnt / SC) % 2) == 1) ? ALL_ON : '0;
          end
          2: begin
            if (!p) begin
              m_cnt++;
              if (m_cnt % SC == 0) exp_tick = 1'b1;
            end
            exp_led = N'(1) << ((m_cnt / SC) % N);
          end
          3: begin
            exp_led = (pwm_before < duty_before) ? ALL_ON : '0;
            if (!p && pwm_before == PWM_PERIOD - 1) begin
              m_wraps++;
              if (m_wraps % BD == 0) exp_tick = 1'b1;
            end
          end
          default: exp_led = '0;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'b01, 1'b0);
      total++;
      if (led !== 4'b0000 || step_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d led=%b tick=%b expected led=0000 tick=0", i, led, step_tick);
      end
    end
  endtask

  task automatic test_blink();
    for (int i = 0; i <= 12; i++) begin
      cycle(1'b1, 2'b01, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL blink cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
      if (i == 4 || i == 8) begin
        total++;
        if (led !== ((i == 4) ? 4'b1111 : 4'b0000)) begin
          bad++;
          $display("FAIL blink_edge cyc=%0d led=%b expected %b", i, led, (i == 4) ? 4'b1111 : 4'b0000);
        end
      end
    end
  endtask

  task automatic test_marquee();
    for (int i = 0; i <= 22; i++) begin
      cycle(1'b1, 2'b10, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL marquee cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
    end
    // Switch to blink part-way through a step; counter must restart.
    for (int i = 0; i <= 9; i++) begin
      cycle(1'b1, 2'b01, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL marquee_switch cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
      if (i == 0 || i == 3) begin
        total++;
        if (led !== 4'b0000) begin
          bad++;
          $display("FAIL marquee_switch_hold cyc=%0d led=%b expected 0000", i, led);
        end
      end
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i <= 10; i++) begin
      cycle(1'b1, 2'b10, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL pause_pre cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'b10, 1'b1);
      total++;
      if (led !== 4'b0100 || step_tick !== 1'b0 || led !== exp_led) begin
        bad++;
        $display("FAIL pause_hold cyc=%0d led=%b tick=%b expected led=0100 tick=0", i, led, step_tick);
      end
    end
    // Two counts elapsed before the pause, so the step lands two edges later.
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 2'b10, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL pause_resume cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
      if (i == 2) begin
        total++;
        if (led !== 4'b1000) begin
          bad++;
          $display("FAIL pause_resume_step led=%b expected 1000", led);
        end
      end
    end
  endtask

  task automatic test_breathe();
    int high_cnt;
    int win;
    high_cnt = 0;
    win = 0;
    for (int i = 0; i < FADE * PWM_PERIOD * BD + 48; i++) begin
      cycle(1'b1, 2'b11, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL breathe cyc=%0d led=%b tick=%b expected led=%b tick=%b duty=%0d", i, led, step_tick, exp_led, exp_tick, model_duty());
      end
      if (model_duty() == 3 && win < PWM_PERIOD && i > PWM_PERIOD) begin
        if (led === ALL_ON) high_cnt++;
        win++;
        if (win == PWM_PERIOD) begin
          total++;
          if (high_cnt !== 3) begin
            bad++;
            $display("FAIL breathe_duty3 high=%0d expected 3", high_cnt);
          end
        end
      end
    end
  endtask

  task automatic test_midrun_reset();
    int guard;
    guard = 0;
    cycle(1'b1, 2'b11, 1'b0);
    while (!(model_duty() == 5 && m_wraps % BD == 0) && guard < 2000) begin
      cycle(1'b1, 2'b11, 1'b0);
      guard++;
    end
    total++;
    if (guard >= 2000) begin
      bad++;
      $display("FAIL midrun_reach duty=%0d expected 5 within budget", model_duty());
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'b11, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL midrun_pre cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
    end
    cycle(1'b0, 2'b11, 1'b0);
    total++;
    if (led !== 4'b0000 || step_tick !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset led=%b tick=%b expected led=0000 tick=0", led, step_tick);
    end
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 2'b11, 1'b0);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL midrun_reload cyc=%0d led=%b tick=%b expected led=%b tick=%b", i, led, step_tick, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] md;
    logic       p;
    logic       r;
    md = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) != 0);
      cycle(r, md, p);
      total++;
      if (led !== exp_led || step_tick !== exp_tick) begin
        bad++;
        $display("FAIL random cyc=%0d mode=%b pause=%b led=%b tick=%b expected led=%b tick=%b", i, md, p, led, step_tick, exp_led, exp_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_marquee();
    test_pause();
    test_breathe();
    test_midrun_reset();
    cycle(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'b00, 1'b0);
      total++;
      if (led !== 4'b0000 || step_tick !== 1'b0) begin
        bad++;
        $display("FAIL off cyc=%0d led=%b tick=%b expected led=0000 tick=0", i, led, step_tick);
      end
    end
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator, the multi-mode successor to the board's fixed-rate LED blinker. It drives a `LED_NUM`-wide LED bank in one of four runtime-selectable modes: off, blink, marquee (running light) and breathe (PWM fade). It also exports a step strobe for other status logic. It sits at board top level, directly on the LED pins.

## Interface

**Parameters**
- `LED_NUM`, default 8: number of LEDs, ≥1.
- `STEP_CYCLES`, default 25_000_000: clk cycles per blink/marquee step, ≥2.
- `PWM_BITS`, default 8: PWM counter/duty width, ≥2.
- `BREATH_DIV`, default 256: PWM periods per duty step in breathe mode, ≥1.

**Ports**
- `clk`, in, 1: system clock.
- `rstn`, in, 1: reset; synchronous, active-low; clock `clk`.
- `mode`, in, 2: 00 off, 01 blink, 10 marquee, 11 breathe.
- `pause`, in, 1: freeze the pattern while high.
- `led`, out, `LED_NUM`: LED drive, registered.
- `step_tick`, out, 1: one-cycle strobe on each pattern step.

## Operation

- **Reset (`rstn`=0 at an edge):**
  - step counter, PWM counter, BREATH_DIV counter and duty are cleared; direction is set to up.
  - `mode_q` is set to 00.
  - `led` is all-0; `step_tick` is 0.
  - Reset mid-operation aborts any pattern immediately.
- **Mode load:**
  - A mode load happens on any edge where `mode` != `mode_q`.
  - On that edge: `mode_q` <= `mode`, the step counter and BREATH_DIV counter are cleared, and the pattern is initialised.
  - Initial pattern per mode: off → `led`=0; blink → `led`=0; marquee → `led`=1 (bit0 set); breathe → duty=0, direction up.
  - A mode load takes priority over `pause` and over any step on the same edge.
- **Step counter:**
  - Counts 0..STEP_CYCLES-1 in blink and marquee; held at 0 in off and breathe.
  - The wrap edge (counter==STEP_CYCLES-1) performs one step.
- **Blink:** each step inverts all `led` bits.
- **Marquee:** each step rotates `led` left by 1; the MSB wraps to bit0. `LED_NUM`=1 holds the LED at 1.
- **Breathe:**
  - `pwm_cnt` (`PWM_BITS` wide) is free-running and wraps naturally.
  - `led` = all bits equal to (`pwm_cnt` < duty), registered.
  - The BREATH_DIV counter increments on each `pwm_cnt` wrap (`pwm_cnt` == all-1s). When it reaches BREATH_DIV-1, that same wrap is a duty step and the counter clears.
  - On a duty step while direction is up: duty +1. If the new duty equals 2^PWM_BITS-1, direction flips to down.
  - On a duty step while direction is down: duty −1. If the new duty equals 0, direction flips to up.
  - Duty never overflows or underflows.
- **Pause:**
  - While high, the step counter, BREATH_DIV counter, duty and pattern hold; no `step_tick` is produced.
  - `pwm_cnt` keeps running, so breathe brightness holds.
- **Off:** `led`=0 and `step_tick`=0 permanently.

## Timing

- `step_tick` is registered. It is high for the one cycle following each step edge: the blink/marquee wrap or the breathe duty step.
- Latency: the first blink/marquee step occurs STEP_CYCLES edges after the mode-load edge; later steps follow every STEP_CYCLES edges.
- Breathe period: one duty step every 2^PWM_BITS × BREATH_DIV cycles. A full fade cycle is 2·(2^PWM_BITS−1) duty steps.
- Breathe `led` lags `pwm_cnt` by 1 cycle.
- `pause` is sampled at each edge; resuming continues the count from the held value.

## Configuration

- **`LED_ACTIVE_LOW_EN` defined:** the `led` port is the bitwise inverse of the internal pattern, for active-low boards. The reset value of `led` becomes all-1.
- **Undefined:** `led` is active-high, as described above.
- `step_tick` is unaffected either way.

## Test plan

Use `LED_NUM`=4, `STEP_CYCLES`=4, `PWM_BITS`=3, `BREATH_DIV`=2, macro undefined.

- **Reset:** hold `rstn`=0 for 3 cycles with `mode`=01 → `led`=0000, `step_tick`=0 throughout.
- **Blink:** `mode`=01 after reset → `led` goes 0000→1111→0000 at edges 4 and 8 after the load edge; `step_tick` is high the cycle after each.
- **Marquee:** `mode`=10 → `led` goes 0001, 0010, 0100, 1000, 0001 every 4 edges. Switch to `mode`=01 mid-step → `led`=0000 on the next edge and the counter restarts.
- **Breathe:**
  - `mode`=11 → duty goes 0,1,…,7,6,…,0,1, one step every 16 cycles.
  - At duty=3, `led`=1111 for 3 of every 8 cycles.
  - Duty never goes beyond 7 or below 0.
- **Pause:** assert `pause` for 10 cycles in marquee at `led`=0100 → `led` holds and there is no `step_tick`. Resuming gives the next step exactly 4 − (elapsed count) edges later.
- **Mid-run reset:** assert `rstn`=0 in breathe at duty=5 → next cycle `led`=0000, duty=0, `mode_q`=00; a mode reload follows on release.
